// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared widths, control-bit layout and the NOP control word
package id_ex_stage_reg_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;
    localparam int CTRL_W     = 9;

    localparam int CTRL_REG_DST       = 8;
    localparam int CTRL_ALU_SRC       = 7;
    localparam int CTRL_MEM_READ      = 6;
    localparam int CTRL_MEM_WRITE     = 5;
    localparam int CTRL_MEM_TO_REG    = 4;
    localparam int CTRL_REG_WRITE     = 3;
    localparam int CTRL_LINK          = 2;
    localparam int CTRL_MEM_WIDTH_MSB = 1;
    localparam int CTRL_MEM_WIDTH_LSB = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: generic register with enable, synchronous clear and active-low sync reset
module pipe_reg #(
    parameter int SIZE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            clear,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);
    always_ff @(posedge clk)
        if (!reset_n) q <= '0;
        else if (enable) q <= clear ? '0 : d;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with halt, bubble/flush squash and bubble counter
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::CTRL_W, id_ex_stage_reg_pkg::CTRL_NOP;
#(
    parameter int DATA_W     = id_ex_stage_reg_pkg::DATA_W,
    parameter int REG_ADDR_W = id_ex_stage_reg_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = id_ex_stage_reg_pkg::ALUOP_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_bubble,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_pc_plus4,
    input  logic [DATA_W-1:0]     i_rs_data,
    input  logic [DATA_W-1:0]     i_rt_data,
    input  logic [DATA_W-1:0]     i_imm,
    input  logic [4:0]            i_shamt,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [ALUOP_W-1:0]    i_alu_op,
    input  logic [CTRL_W-1:0]     i_ctrl,
    output logic [DATA_W-1:0]     o_pc_plus4,
    output logic [DATA_W-1:0]     o_rs_data,
    output logic [DATA_W-1:0]     o_rt_data,
    output logic [DATA_W-1:0]     o_imm,
    output logic [4:0]            o_shamt,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [ALUOP_W-1:0]    o_alu_op,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic                  o_valid,
    output logic [15:0]           o_bubble_cnt
);
    localparam int DW = 4*DATA_W + 5 + 3*REG_ADDR_W;
    localparam int CW = ALUOP_W + CTRL_W + 1;

    logic squash;
    assign squash = i_flush | i_bubble;

    // data fields still load on a squash so the waveform shows what was dropped
    pipe_reg #(.SIZE(DW)) u_data (
        .clk(i_clk), .reset_n(i_reset), .enable(i_enable), .clear(1'b0),
        .d({i_pc_plus4, i_rs_data, i_rt_data, i_imm, i_shamt, i_rs, i_rt, i_rd}),
        .q({o_pc_plus4, o_rs_data, o_rt_data, o_imm, o_shamt, o_rs, o_rt, o_rd})
    );

    // an invalid slot keeps its alu_op but never carries control side effects
    pipe_reg #(.SIZE(CW)) u_ctrl (
        .clk(i_clk), .reset_n(i_reset), .enable(i_enable), .clear(squash),
        .d({i_alu_op, i_valid ? i_ctrl : CTRL_NOP, i_valid}),
        .q({o_alu_op, o_ctrl, o_valid})
    );

    always_ff @(posedge i_clk)
        if (!i_reset) o_bubble_cnt <= '0;
        else if (i_enable && squash && !(&o_bubble_cnt)) o_bubble_cnt <= o_bubble_cnt + 16'd1;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed self-checking bench for the ID/EX pipeline register
module tb_id_ex_stage_reg;
    logic        i_clk = 1'b0;
    logic        i_reset, i_enable, i_bubble, i_flush, i_valid;
    logic [31:0] i_pc_plus4, i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_shamt, i_rs, i_rt, i_rd;
    logic [3:0]  i_alu_op;
    logic [8:0]  i_ctrl;
    logic [31:0] o_pc_plus4, o_rs_data, o_rt_data, o_imm;
    logic [4:0]  o_shamt, o_rs, o_rt, o_rd;
    logic [3:0]  o_alu_op;
    logic [8:0]  o_ctrl;
    logic        o_valid;
    logic [15:0] o_bubble_cnt;
    int          passed = 0;
    int          total = 0;
    logic [147:0] dat_o, exp_dat;
    logic [15:0]  exp_cnt;

    assign dat_o = {o_pc_plus4, o_rs_data, o_rt_data, o_imm, o_shamt, o_rs, o_rt, o_rd};

    id_ex_stage_reg dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_bubble(i_bubble),
        .i_flush(i_flush), .i_valid(i_valid), .i_pc_plus4(i_pc_plus4), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_imm(i_imm), .i_shamt(i_shamt), .i_rs(i_rs), .i_rt(i_rt),
        .i_rd(i_rd), .i_alu_op(i_alu_op), .i_ctrl(i_ctrl), .o_pc_plus4(o_pc_plus4),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm), .o_shamt(o_shamt),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_alu_op(o_alu_op), .o_ctrl(o_ctrl),
        .o_valid(o_valid), .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] pc, rsd, rtd, imm, input logic [4:0] sh, rs, rt, rd);
        {i_pc_plus4, i_rs_data, i_rt_data, i_imm} = {pc, rsd, rtd, imm};
        {i_shamt, i_rs, i_rt, i_rd} = {sh, rs, rt, rd};
        exp_dat = {pc, rsd, rtd, imm, sh, rs, rt, rd};
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_enable = 1'b1; i_bubble = 1'b1; i_flush = 1'b1; i_valid = 1'b1;
        set_data('1, '1, '1, '1, '1, '1, '1, '1);
        i_alu_op = '1; i_ctrl = '1;
        tick(); tick();
        total++; if (dat_o !== '0) $display("FAIL reset_data got=%h exp=0", dat_o); else passed++;
        total++; if ({o_alu_op, o_ctrl, o_valid} !== 14'h0) $display("FAIL reset_ctrl got=%h/%h/%b exp=0", o_alu_op, o_ctrl, o_valid); else passed++;
        total++; if (o_bubble_cnt !== 16'h0) $display("FAIL reset_cnt got=%h exp=0", o_bubble_cnt); else passed++;
        i_reset = 1'b1; i_bubble = 1'b0; i_flush = 1'b0;
        tick();
        total++; if (dat_o !== exp_dat) $display("FAIL release_data got=%h exp=%h", dat_o, exp_dat); else passed++;
        total++; if ({o_alu_op, o_ctrl, o_valid} !== {4'hF, 9'h1FF, 1'b1}) $display("FAIL release_ctrl got=%h/%h/%b exp=f/1ff/1", o_alu_op, o_ctrl, o_valid); else passed++;
        total++; if (o_bubble_cnt !== 16'h0) $display("FAIL release_cnt got=%h exp=0", o_bubble_cnt); else passed++;
    endtask

    task automatic test_normal();
        set_data(32'h0000_1004, 32'h0000_00AA, 32'h1234_5678, 32'hFFFF_FFFC, 5'd3, 5'd1, 5'd2, 5'd3);
        i_alu_op = 4'h2; i_ctrl = 9'b0_1_1_0_1_1_0_11; i_valid = 1'b1;
        #2;
        total++; if (o_ctrl !== 9'h1FF) $display("FAIL normal_no_comb got=%h exp=1ff", o_ctrl); else passed++;
        tick();
        total++; if (dat_o !== exp_dat) $display("FAIL normal_data got=%h exp=%h", dat_o, exp_dat); else passed++;
        total++; if ({o_alu_op, o_ctrl, o_valid} !== {4'h2, 9'b0_1_1_0_1_1_0_11, 1'b1}) $display("FAIL normal_ctrl got=%h/%h/%b exp=2/0db/1", o_alu_op, o_ctrl, o_valid); else passed++;
    endtask

    task automatic test_bubble();
        set_data(32'h0000_2000, 32'h11, 32'h22, 32'h33, 5'd4, 5'd5, 5'd6, 5'd7);
        i_bubble = 1'b1; i_ctrl = 9'h1FF; i_alu_op = 4'hF;
        tick();
        total++; if ({o_alu_op, o_ctrl, o_valid} !== 14'h0) $display("FAIL bubble_ctrl got=%h/%h/%b exp=0", o_alu_op, o_ctrl, o_valid); else passed++;
        total++; if (o_bubble_cnt !== 16'd1) $display("FAIL bubble_cnt got=%h exp=1", o_bubble_cnt); else passed++;
        total++; if (dat_o !== exp_dat) $display("FAIL bubble_data got=%h exp=%h", dat_o, exp_dat); else passed++;
        i_bubble = 1'b0;
        tick();
        total++; if ({o_alu_op, o_ctrl, o_valid} !== {4'hF, 9'h1FF, 1'b1}) $display("FAIL after_bubble_ctrl got=%h/%h/%b exp=f/1ff/1", o_alu_op, o_ctrl, o_valid); else passed++;
        total++; if (o_bubble_cnt !== 16'd1) $display("FAIL after_bubble_cnt got=%h exp=1", o_bubble_cnt); else passed++;
    endtask

    task automatic test_halt();
        logic [147:0] held;
        held = exp_dat;
        i_enable = 1'b0; i_flush = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_data(32'hA0 + k, 32'hB0 + k, 32'hC0 + k, 32'hD0 + k, 5'(k), 5'(k + 8), 5'(k + 16), 5'(k + 24));
            i_alu_op = 4'(k); i_ctrl = 9'(k + 1);
            tick();
            total++; if (dat_o !== held) $display("FAIL halt_data%0d got=%h exp=%h", k, dat_o, held); else passed++;
            total++; if ({o_alu_op, o_ctrl, o_valid, o_bubble_cnt} !== {4'hF, 9'h1FF, 1'b1, 16'd1}) $display("FAIL halt_ctrl%0d got=%h/%h/%b/%h exp=f/1ff/1/1", k, o_alu_op, o_ctrl, o_valid, o_bubble_cnt); else passed++;
        end
        i_enable = 1'b1; i_flush = 1'b0;
        tick();
        total++; if (dat_o !== exp_dat) $display("FAIL resume_data got=%h exp=%h", dat_o, exp_dat); else passed++;
        total++; if ({o_alu_op, o_ctrl, o_valid, o_bubble_cnt} !== {4'h4, 9'h005, 1'b1, 16'd1}) $display("FAIL resume_ctrl got=%h/%h/%b/%h exp=4/005/1/1", o_alu_op, o_ctrl, o_valid, o_bubble_cnt); else passed++;
    endtask

    task automatic test_back_to_back_squash();
        i_flush = 1'b1; i_bubble = 1'b1; i_ctrl = 9'h1FF;
        tick(); tick(); tick();
        total++; if (o_bubble_cnt !== 16'd4) $display("FAIL both_cnt got=%h exp=4", o_bubble_cnt); else passed++;
        total++; if ({o_ctrl, o_valid} !== 10'h0) $display("FAIL both_ctrl got=%h/%b exp=0/0", o_ctrl, o_valid); else passed++;
        i_flush = 1'b0; i_bubble = 1'b0;
    endtask

    task automatic test_invalid();
        i_valid = 1'b0; i_ctrl = 9'h1FF; i_alu_op = 4'h5;
        tick();
        total++; if ({o_alu_op, o_ctrl, o_valid} !== {4'h5, 9'h0, 1'b0}) $display("FAIL invalid_ctrl got=%h/%h/%b exp=5/0/0", o_alu_op, o_ctrl, o_valid); else passed++;
        total++; if (o_bubble_cnt !== 16'd4) $display("FAIL invalid_cnt got=%h exp=4", o_bubble_cnt); else passed++;
        i_valid = 1'b1;
    endtask

    task automatic test_saturate();
        i_flush = 1'b1;
        for (int k = 4; k < 16'hFFFE; k++) tick();
        total++; if (o_bubble_cnt !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", o_bubble_cnt); else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (o_bubble_cnt !== 16'hFFFF) $display("FAIL sat%0d got=%h exp=ffff", k, o_bubble_cnt); else passed++;
        end
        i_flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_enable = 1'b0; i_reset = 1'b0;
        tick();
        total++; if (dat_o !== '0) $display("FAIL midreset_data got=%h exp=0", dat_o); else passed++;
        total++; if ({o_alu_op, o_ctrl, o_valid, o_bubble_cnt} !== 30'h0) $display("FAIL midreset_ctrl got=%h/%h/%b/%h exp=0", o_alu_op, o_ctrl, o_valid, o_bubble_cnt); else passed++;
        i_reset = 1'b1; i_enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bubble();
        test_halt();
        test_back_to_back_squash();
        test_invalid();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
